fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_perf_cnt.sv | 19 +
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared next-PC select codes, NOP encoding, reset PC and fetch state enum
package fetch_pkg;
   localparam logic [1:0] PC_SEL_JAL = 2'd0;
   localparam logic [1:0] PC_SEL_ALU = 2'd1;
   localparam logic [1:0] PC_SEL_PC4 = 2'd2;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;
   typedef enum logic {FILL, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage control, imem and FD/X pipeline signals; counters under FETCH_PERF_CNT_EN
interface fetch_stage_if;
   logic [1:0] pc_sel;
   logic [31:0] jal_target;
   logic [31:0] alu_target;
   logic stall;
   logic [31:0] imem_dout;
   logic [31:0] imem_addr;
   logic [31:0] pc_fd;
   logic [31:0] inst_fd;
   logic fd_valid;
   logic [31:0] pc_x;
   logic [31:0] inst_x;
   logic x_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] inst_cnt;
`endif
   modport master (
      input pc_sel, jal_target, alu_target, stall, imem_dout,
      output imem_addr, pc_fd, inst_fd, fd_valid, pc_x, inst_x, x_valid
`ifdef FETCH_PERF_CNT_EN
      , output cycle_cnt, inst_cnt
`endif
   );
   modport slave (
      output pc_sel, jal_target, alu_target, stall, imem_dout,
      input imem_addr, pc_fd, inst_fd, fd_valid, pc_x, inst_x, x_valid
`ifdef FETCH_PERF_CNT_EN
      , input cycle_cnt, inst_cnt
`endif
   );
endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running cycle counter and retired-into-X instruction counter
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_inc,
   output logic [31:0] cycle_cnt,
   output logic [31:0] inst_cnt
);
   // count every non-reset cycle and every valid instruction entering X
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         inst_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         inst_cnt <= inst_cnt + {31'd0, inst_inc};
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem addressing and FD->X register; optional counters via FETCH_PERF_CNT_EN
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input logic clk,
   input logic rst,
   fetch_stage_if.master bus
);
   fetch_state_t state;
   logic [31:0] next_pc;
   logic squash;
   // next-PC choice, fetch address (holds on stall so imem_dout stays stable) and NOP gating of FD
   always_comb begin
      squash = bus.pc_sel == PC_SEL_ALU;
      next_pc = |(bus.pc_sel & PC_SEL_PC4) ? bus.pc_fd + 32'd4 :
                squash ? bus.alu_target & ~32'd1 : bus.jal_target;
      bus.imem_addr = state == FILL ? RESET_PC : bus.stall ? bus.pc_fd : next_pc;
      bus.inst_fd = bus.fd_valid ? bus.imem_dout : NOP_INST;
   end
   // FILL primes the first fetch; RUN advances PC and FD->X unless stalled, bubbling X on an X redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
         bus.pc_fd <= RESET_PC;
         bus.fd_valid <= 1'b0;
         bus.pc_x <= '0;
         bus.inst_x <= NOP_INST;
         bus.x_valid <= 1'b0;
      end else if (state == FILL) begin
         state <= RUN;
         bus.pc_fd <= RESET_PC;
         bus.fd_valid <= 1'b1;
      end else if (!bus.stall) begin
         bus.pc_fd <= next_pc;
         bus.pc_x <= bus.pc_fd;
         bus.inst_x <= squash ? NOP_INST : bus.inst_fd;
         bus.x_valid <= !squash && bus.fd_valid;
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic inst_inc;
   assign inst_inc = state == RUN && !bus.stall && !squash && bus.fd_valid;
   fetch_perf_cnt u_perf (
      .clk(clk),
      .rst(rst),
      .inst_inc(inst_inc),
      .cycle_cnt(bus.cycle_cnt),
      .inst_cnt(bus.inst_cnt)
   );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus, abstract pipeline model checked every cycle, plus literal pins
module tb_fetch_stage;
   localparam logic [31:0] RST_PC = 32'h4000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0;
   logic rst;
   fetch_stage_if bus();
   fetch_stage #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   always @(posedge clk) bus.imem_dout <= mem(bus.imem_addr);
   int vectors = 0;
   int miscompares = 0;
   bit m_known = 0;
   bit m_fill = 0;
   bit m_fd_valid, m_x_valid;
   logic [31:0] m_pc_fd, m_pc_x, m_inst_x, m_last_addr;
   logic [31:0] m_cyc, m_ic;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step(input bit r, input bit s, input logic [1:0] sel,
                       input logic [31:0] jt, input logic [31:0] at);
      logic [31:0] tgt, addr, ifd;
      rst = r;
      bus.stall = s;
      bus.pc_sel = sel;
      bus.jal_target = jt;
      bus.alu_target = at;
      #1;
      tgt = sel == 2'd0 ? jt : sel == 2'd1 ? {at[31:1], 1'b0} : m_pc_fd + 32'd4;
      addr = m_fill ? RST_PC : s ? m_pc_fd : tgt;
      ifd = m_fd_valid ? mem(m_last_addr) : NOP;
      if (m_known) begin
         if (!r) chk("imem_addr", bus.imem_addr, addr);
         chk("pc_fd", bus.pc_fd, m_pc_fd);
         chk("fd_valid", {31'd0, bus.fd_valid}, {31'd0, m_fd_valid});
         chk("inst_fd", bus.inst_fd, ifd);
         chk("pc_x", bus.pc_x, m_pc_x);
         chk("inst_x", bus.inst_x, m_inst_x);
         chk("x_valid", {31'd0, bus.x_valid}, {31'd0, m_x_valid});
`ifdef FETCH_PERF_CNT_EN
         chk("cycle_cnt", bus.cycle_cnt, m_cyc);
         chk("inst_cnt", bus.inst_cnt, m_ic);
`endif
      end
      if (r) begin
         m_fill = 1;
         m_pc_fd = RST_PC;
         m_fd_valid = 0;
         m_pc_x = '0;
         m_inst_x = NOP;
         m_x_valid = 0;
         m_cyc = '0;
         m_ic = '0;
         m_known = 1;
      end else begin
         m_cyc = m_cyc + 32'd1;
         if (m_fill) begin
            m_fill = 0;
            m_pc_fd = RST_PC;
            m_fd_valid = 1;
         end else if (!s) begin
            m_pc_x = m_pc_fd;
            m_x_valid = sel != 2'd1 && m_fd_valid;
            m_inst_x = sel == 2'd1 ? NOP : ifd;
            if (m_x_valid) m_ic = m_ic + 32'd1;
            m_pc_fd = tgt;
         end
      end
      m_last_addr = addr;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic run4(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'd2, 32'h0, 32'h0);
   endtask
   logic [1:0] sel_tab [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2};
   bit stall_tab [8] = '{0, 1, 0, 1, 1, 0, 0, 1};
   initial begin
      step(1, 0, 2'd2, 32'h0, 32'h0);
      step(1, 0, 2'd2, 32'h0, 32'h0);
      rst = 0;
      #1;
      chk("fill_addr", bus.imem_addr, 32'h4000_0000);
      chk("fill_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
      run4(1);
      chk("c2_pc_fd", bus.pc_fd, 32'h4000_0000);
      chk("c2_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
      run4(1);
      chk("c3_pc_fd", bus.pc_fd, 32'h4000_0004);
      chk("c3_x_valid", {31'd0, bus.x_valid}, 32'd1);
      chk("c3_pc_x", bus.pc_x, 32'h4000_0000);
      run4(1);
      step(0, 0, 2'd0, 32'h4000_0100, 32'h0);
      chk("jal_pc_fd", bus.pc_fd, 32'h4000_0100);
      chk("jal_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
      chk("jal_pc_x", bus.pc_x, 32'h4000_0008);
      chk("jal_x_valid", {31'd0, bus.x_valid}, 32'd1);
      run4(1);
      step(0, 0, 2'd1, 32'h0, 32'h4000_0201);
      chk("br_pc_fd", bus.pc_fd, 32'h4000_0200);
      chk("br_x_valid", {31'd0, bus.x_valid}, 32'd0);
      chk("br_inst_x", bus.inst_x, 32'h0000_0013);
      run4(1);
      for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 32'h0, 32'h1234_5679);
      chk("stall_pc_fd", bus.pc_fd, 32'h4000_0204);
      chk("stall_x_valid", {31'd0, bus.x_valid}, 32'd1);
      chk("stall_inst_x", bus.inst_x, mem(32'h4000_0200));
      run4(1);
      chk("resume_pc_fd", bus.pc_fd, 32'h4000_0208);
      chk("resume_pc_x", bus.pc_x, 32'h4000_0204);
      step(0, 0, 2'd0, 32'hFFFF_FFFC, 32'h0);
      step(0, 0, 2'd2, 32'h0, 32'h0);
      chk("wrap_pc_fd", bus.pc_fd, 32'h0000_0000);
      run4(1);
      step(1, 0, 2'd2, 32'h0, 32'h0);
      chk("mid_rst_x_valid", {31'd0, bus.x_valid}, 32'd0);
      chk("mid_rst_pc_fd", bus.pc_fd, 32'h4000_0000);
      run4(3);
      for (int i = 0; i < 8; i++) step(0, stall_tab[i], sel_tab[i], 32'h4000_0800 + 32'(i * 16), 32'h4000_0A01 + 32'(i * 32));
      step(1, 0, 2'd2, 32'h0, 32'h0);
      run4(3);
      step(0, 0, 2'd1, 32'h0, 32'h4000_0301);
      step(0, 1, 2'd2, 32'h0, 32'h0);
      step(0, 1, 2'd2, 32'h0, 32'h0);
      run4(4);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_cycle_cnt", bus.cycle_cnt, 32'd10);
      chk("perf_inst_cnt", bus.inst_cnt, 32'd6);
`endif
      run4(1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
